// File: rtl/stage_reg_mc_pkg.sv
// rtl/stage_reg_mc_pkg.sv - shared encodings for the pipeline stage register (stage_pkg)
package stage_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int NOP_REG_ADDR = 0;

    typedef enum logic [1:0] {
        ST_ADV,
        ST_BUB,
        ST_HOLD,
        ST_FLUSH
    } hold_state_e;

endpackage

// File: rtl/stage_reg_mc_if.sv
// rtl/stage_reg_mc_if.sv - payload and multi-cycle EX bundle crossing the stage register
interface stage_reg_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
);
    logic [ADDR_W-1:0]   in_wd;
    logic                in_wreg;
    logic [DATA_W-1:0]   in_wdata;
    logic [DATA_W-1:0]   in_hi;
    logic [DATA_W-1:0]   in_lo;
    logic                in_whilo;
    logic [2*DATA_W-1:0] acc_i;
    logic [CNT_W-1:0]    cnt_i;

    logic                out_valid;
    logic [ADDR_W-1:0]   out_wd;
    logic                out_wreg;
    logic [DATA_W-1:0]   out_wdata;
    logic [DATA_W-1:0]   out_hi;
    logic [DATA_W-1:0]   out_lo;
    logic                out_whilo;
    logic [2*DATA_W-1:0] acc_o;
    logic [CNT_W-1:0]    cnt_o;

    modport master (
        output in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo, acc_i, cnt_i,
        input  out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo, acc_o, cnt_o
    );

    modport slave (
        input  in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo, acc_i, cnt_i,
        output out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo, acc_o, cnt_o
    );
endinterface

// File: rtl/stage_reg_mc_hold_wdog.sv
// rtl/stage_reg_mc_hold_wdog.sv - saturating consecutive-hold counter with sticky timeout (stage_hold_wdog)
module stage_hold_wdog #(
    parameter int HOLD_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hold_timeout
);
    localparam logic [15:0] MAX_M1 = 16'(HOLD_MAX - 1);

    logic [15:0] hold_cnt;

    // Count stalled cycles, saturating; the flag sets on the edge the count reaches HOLD_MAX
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else if (inc) begin
            if (hold_cnt != 16'hFFFF) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
            if (hold_cnt >= MAX_M1) begin
                hold_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/stage_reg_mc.sv
// rtl/stage_reg_mc.sv - EX->MEM stage register with flush, valid flag and hold watchdog; option STAGE_REG_PERF_EN
module stage_reg_mc
    import stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 3,
    parameter int HOLD_MAX  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    stage_reg_mc_if.slave      bus,
    output logic               hold_timeout,
    output logic [31:0]        bubble_cnt
);
    logic        dn;
    hold_state_e act;

    // The last stage in the vector has nobody downstream to wait for
    if (STAGE_IDX < STALL_W - 1) begin : g_dn
        assign dn = stall[STAGE_IDX+1];
    end else begin : g_no_dn
        assign dn = 1'b0;
    end

    // Decode this edge's action; a downstream stall without our own stall still advances
    always_comb begin
        act = ST_ADV;
        if (flush) begin
            act = ST_FLUSH;
        end else if (stall[STAGE_IDX] == NOSTOP) begin
            act = ST_ADV;
        end else if (dn == STOP) begin
            act = ST_HOLD;
        end else begin
            act = ST_BUB;
        end
    end

    // Payload, valid flag and the multi-cycle state returned to EX
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_wd    <= ADDR_W'(NOP_REG_ADDR);
            bus.out_wreg  <= 1'b0;
            bus.out_wdata <= '0;
            bus.out_hi    <= '0;
            bus.out_lo    <= '0;
            bus.out_whilo <= 1'b0;
            bus.acc_o     <= '0;
            bus.cnt_o     <= '0;
        end else begin
            case (act)
                ST_ADV: begin
                    bus.out_valid <= 1'b1;
                    bus.out_wd    <= bus.in_wd;
                    bus.out_wreg  <= bus.in_wreg;
                    bus.out_wdata <= bus.in_wdata;
                    bus.out_hi    <= bus.in_hi;
                    bus.out_lo    <= bus.in_lo;
                    bus.out_whilo <= bus.in_whilo;
                    bus.acc_o     <= '0;
                    bus.cnt_o     <= '0;
                end
                ST_HOLD: begin
                    bus.acc_o <= bus.acc_i;
                    bus.cnt_o <= bus.cnt_i;
                end
                default: begin
                    // Flush and bubble both insert a NOP; only a bubble keeps the EX op alive
                    bus.out_valid <= 1'b0;
                    bus.out_wd    <= ADDR_W'(NOP_REG_ADDR);
                    bus.out_wreg  <= 1'b0;
                    bus.out_wdata <= '0;
                    bus.out_hi    <= '0;
                    bus.out_lo    <= '0;
                    bus.out_whilo <= 1'b0;
                    bus.acc_o     <= (act == ST_BUB) ? bus.acc_i : '0;
                    bus.cnt_o     <= (act == ST_BUB) ? bus.cnt_i : '0;
                end
            endcase
        end
    end

    stage_hold_wdog #(
        .HOLD_MAX (HOLD_MAX)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .clr          ((act == ST_ADV) || (act == ST_FLUSH)),
        .inc          ((act == ST_BUB) || (act == ST_HOLD)),
        .hold_timeout (hold_timeout)
    );

`ifdef STAGE_REG_PERF_EN
    // Free-running bubble count, wraps, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (act == ST_BUB) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_stage_reg_mc.sv
// tb/tb_stage_reg_mc.sv - directed self-checking bench for stage_reg_mc
module tb_stage_reg_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        hold_timeout;
    logic [31:0] bubble_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    stage_reg_mc_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) bus ();

    stage_reg_mc dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .bus          (bus),
        .hold_timeout (hold_timeout),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                         input logic [63:0] acc, input logic [1:0] cnt);
        bus.in_wd = wd; bus.in_wreg = wreg; bus.in_wdata = wdata;
        bus.in_hi = hi; bus.in_lo = lo; bus.in_whilo = whilo;
        bus.acc_i = acc; bus.cnt_i = cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; stall = 6'($urandom);
        drive(5'($urandom), 1'b1, $urandom, $urandom, $urandom, 1'b1, {$urandom, $urandom}, 2'($urandom));
        step();
        stall = 6'($urandom);
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", bus.out_valid); end
        n_cmp++; if (bus.out_wd !== 5'd0) begin n_err++; $display("FAIL reset_wd got %0h want 0", bus.out_wd); end
        n_cmp++; if ({bus.out_wreg, bus.out_whilo} !== 2'b00) begin n_err++; $display("FAIL reset_we got %0h want 0", {bus.out_wreg, bus.out_whilo}); end
        n_cmp++; if ({bus.out_wdata, bus.out_hi, bus.out_lo} !== 96'd0) begin n_err++; $display("FAIL reset_data got %0h want 0", {bus.out_wdata, bus.out_hi, bus.out_lo}); end
        n_cmp++; if ({bus.acc_o, bus.cnt_o} !== 66'd0) begin n_err++; $display("FAIL reset_acc got %0h want 0", {bus.acc_o, bus.cnt_o}); end
        n_cmp++; if (hold_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %0h want 0", hold_timeout); end
        n_cmp++; if (bubble_cnt !== 32'd0) begin n_err++; $display("FAIL reset_bubble got %0h want 0", bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_advance();
        stall = 6'b000000; flush = 1'b0;
        drive(5'd5, 1'b1, 32'hDEADBEEF, 32'h11, 32'h22, 1'b1, 64'h99, 2'd3);
        step();
        n_cmp++; if (bus.out_wd !== 5'd5) begin n_err++; $display("FAIL adv_wd got %0h want 5", bus.out_wd); end
        n_cmp++; if (bus.out_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL adv_wdata got %0h want deadbeef", bus.out_wdata); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL adv_valid got %0h want 1", bus.out_valid); end
        n_cmp++; if ({bus.out_hi, bus.out_lo, bus.out_wreg, bus.out_whilo} !== {32'h11, 32'h22, 2'b11}) begin n_err++; $display("FAIL adv_hilo got %0h want %0h", {bus.out_hi, bus.out_lo, bus.out_wreg, bus.out_whilo}, {32'h11, 32'h22, 2'b11}); end
        n_cmp++; if ({bus.acc_o, bus.cnt_o} !== 66'd0) begin n_err++; $display("FAIL adv_acc got %0h want 0", {bus.acc_o, bus.cnt_o}); end
    endtask

    task automatic test_bubble();
        stall = 6'b001111;
        drive(5'd7, 1'b1, 32'h77, 32'h1, 32'h2, 1'b1, 64'h1234, 2'd1);
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bub_valid got %0h want 0", bus.out_valid); end
        n_cmp++; if (bus.out_wreg !== 1'b0) begin n_err++; $display("FAIL bub_wreg got %0h want 0", bus.out_wreg); end
        n_cmp++; if ({bus.out_wd, bus.out_wdata} !== 37'd0) begin n_err++; $display("FAIL bub_payload got %0h want 0", {bus.out_wd, bus.out_wdata}); end
        n_cmp++; if (bus.acc_o !== 64'h1234) begin n_err++; $display("FAIL bub_acc got %0h want 1234", bus.acc_o); end
        n_cmp++; if (bus.cnt_o !== 2'd1) begin n_err++; $display("FAIL bub_cnt got %0h want 1", bus.cnt_o); end
    endtask

    task automatic test_hold();
        stall = 6'b000000;
        drive(5'd9, 1'b1, 32'hCAFEF00D, 32'h3, 32'h4, 1'b0, 64'h0, 2'd0);
        step();
        stall = 6'b011111;
        drive(5'd12, 1'b0, 32'h0BAD0BAD, 32'h5, 32'h6, 1'b1, 64'hAB, 2'd2);
        for (int i = 1; i <= 14; i++) begin
            step();
            n_cmp++; if (hold_timeout !== 1'b0) begin n_err++; $display("FAIL hold_early_timeout cyc %0d got %0h want 0", i, hold_timeout); end
        end
        step();
        n_cmp++; if (hold_timeout !== 1'b1) begin n_err++; $display("FAIL hold_timeout got %0h want 1", hold_timeout); end
        n_cmp++; if ({bus.out_valid, bus.out_wd, bus.out_wdata} !== {1'b1, 5'd9, 32'hCAFEF00D}) begin n_err++; $display("FAIL hold_payload got %0h want %0h", {bus.out_valid, bus.out_wd, bus.out_wdata}, {1'b1, 5'd9, 32'hCAFEF00D}); end
        n_cmp++; if ({bus.acc_o, bus.cnt_o} !== {64'hAB, 2'd2}) begin n_err++; $display("FAIL hold_acc got %0h want %0h", {bus.acc_o, bus.cnt_o}, {64'hAB, 2'd2}); end
        step();
        n_cmp++; if (hold_timeout !== 1'b1) begin n_err++; $display("FAIL hold_sticky got %0h want 1", hold_timeout); end
        stall = 6'b000000;
        step();
        n_cmp++; if (hold_timeout !== 1'b0) begin n_err++; $display("FAIL hold_clear got %0h want 0", hold_timeout); end
        n_cmp++; if ({bus.out_wd, bus.out_wdata} !== {5'd12, 32'h0BAD0BAD}) begin n_err++; $display("FAIL hold_release got %0h want %0h", {bus.out_wd, bus.out_wdata}, {5'd12, 32'h0BAD0BAD}); end
    endtask

    task automatic test_flush();
        stall = 6'b011111;
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (hold_timeout !== 1'b1) begin n_err++; $display("FAIL flush_pre_timeout got %0h want 1", hold_timeout); end
        stall = 6'b001111; flush = 1'b1;
        drive(5'd3, 1'b1, 32'h55, 32'h1, 32'h1, 1'b1, 64'h55, 2'd2);
        step();
        flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0h want 0", bus.out_valid); end
        n_cmp++; if ({bus.acc_o, bus.cnt_o} !== 66'd0) begin n_err++; $display("FAIL flush_acc got %0h want 0", {bus.acc_o, bus.cnt_o}); end
        n_cmp++; if ({bus.out_wd, bus.out_wreg, bus.out_wdata} !== 38'd0) begin n_err++; $display("FAIL flush_payload got %0h want 0", {bus.out_wd, bus.out_wreg, bus.out_wdata}); end
        n_cmp++; if (hold_timeout !== 1'b0) begin n_err++; $display("FAIL flush_timeout got %0h want 0", hold_timeout); end
    endtask

    task automatic test_protocol_err();
        stall = 6'b010000;
        drive(5'd17, 1'b1, 32'h600D, 32'h0, 32'h0, 1'b0, 64'h7, 2'd1);
        step();
        n_cmp++; if ({bus.out_valid, bus.out_wd, bus.cnt_o} !== {1'b1, 5'd17, 2'd0}) begin n_err++; $display("FAIL proto_adv got %0h want %0h", {bus.out_valid, bus.out_wd, bus.cnt_o}, {1'b1, 5'd17, 2'd0}); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_bub;
`ifdef STAGE_REG_PERF_EN
        exp_bub = 32'd7;
`else
        exp_bub = 32'd0;
`endif
        rst = 1'b1; step(); rst = 1'b0;
        stall = 6'b001111;
        for (int i = 0; i < 7; i++) step();
        n_cmp++; if (bubble_cnt !== exp_bub) begin n_err++; $display("FAIL perf_count got %0d want %0d", bubble_cnt, exp_bub); end
        flush = 1'b1; step(); flush = 1'b0;
        n_cmp++; if (bubble_cnt !== exp_bub) begin n_err++; $display("FAIL perf_flush got %0d want %0d", bubble_cnt, exp_bub); end
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++; if (bubble_cnt !== 32'd0) begin n_err++; $display("FAIL perf_reset got %0d want 0", bubble_cnt); end
        stall = 6'b000000;
    endtask

    initial begin
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_protocol_err();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
